ysyx_22051013_dmem_responder: RTL and testbench

Data-side memory responder: the slave end of the LSU load/store request interface. It samples re/we/fencei requests, serves them from an internal byte-maskable 64-bit-wide SRAM after a fixed latency, and returns a full aligned doubleword with an active-low completion strobe. The response is held under core_ready backpressure. It replaces the dcache/AXI path in standalone and pipeline bring-up benches.

---
 rtl/ysyx_22051013_dmem_responder_pkg.sv | 21 ++
 rtl/ysyx_22051013_dsram.sv | 44 ++++
 rtl/ysyx_22051013_dmem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_ysyx_22051013_dmem_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22051013_dmem_responder_pkg.sv
// Shared definitions for the data-side memory responder.
//   - FSM state encoding for the responder control path
//   - data_size codes (byte / half / word / double)
//   - default base address of the served window and a 64-bit zero constant
package ysyx_22051013_dmem_responder_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } dmem_state_e;

   localparam logic [2:0] SizeB = 3'd0;
   localparam logic [2:0] SizeH = 3'd1;
   localparam logic [2:0] SizeW = 3'd2;
   localparam logic [2:0] SizeD = 3'd3;

   localparam logic [63:0] DefaultBaseAddr = 64'h0000_0000_8000_0000;
   localparam logic [63:0] Zero64          = 64'd0;

endpackage

// File: rtl/ysyx_22051013_dsram.sv
// Synchronous single-port 2^DEPTH_LOG2 x 64 RAM with per-byte write enable
// and a registered read port. Contents are not reset.
// Ports:
//   clk      clock
//   i_addr   word index
//   i_we     write strobe, lanes qualified by i_wmask
//   i_wmask  byte-lane write mask
//   i_wdata  write data, lane-aligned
//   i_re     read strobe; o_rdata holds its value until the next read
//   o_rdata  registered read data
module ysyx_22051013_dsram #(
   parameter int unsigned DEPTH_LOG2 = 12
) (
   input  logic                  clk,
   input  logic [DEPTH_LOG2-1:0] i_addr,
   input  logic                  i_we,
   input  logic [7:0]            i_wmask,
   input  logic [63:0]           i_wdata,
   input  logic                  i_re,
   output logic [63:0]           o_rdata
);

   logic [63:0] r_mem [2**DEPTH_LOG2];
   logic [63:0] r_rdata;

   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (i_we && i_wmask[i]) begin
            r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
         end
      end
   end

   // Read register only loads on a read strobe so the response stays stable
   // for as long as the consumer applies backpressure.
   always_ff @(posedge clk) begin
      if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/ysyx_22051013_dmem_responder.sv
// Data-side memory responder: slave end of the LSU load/store interface.
// Samples a re/we/fencei request in IDLE, waits LATENCY cycles, commits the
// access to the internal SRAM on the edge entering RESP and holds the
// response (data_valid low) until core_ready.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   re, we, fencei   request strobes (exactly one expected)
//   core_ready       consumer accepts the response this cycle
//   data_pc          byte address
//   data_o, wlen     store data (lane-aligned) and byte-lane mask
//   data_size        access size code, used for alignment checks
//   data_temp        aligned doubleword response (0 for stores/fence/faults)
//   data_valid       active-low completion strobe
//   resp_err         request faulted
module ysyx_22051013_dmem_responder
   import ysyx_22051013_dmem_responder_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR  = DefaultBaseAddr,
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter int unsigned LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        re,
   input  logic        we,
   input  logic        fencei,
   input  logic        core_ready,
   input  logic [63:0] data_pc,
   input  logic [63:0] data_o,
   input  logic [7:0]  wlen,
   input  logic [2:0]  data_size,
   output logic [63:0] data_temp,
   output logic        data_valid,
   output logic        resp_err
);

   localparam logic [63:0] EndAddr  = BASE_ADDR + (64'd8 << DEPTH_LOG2);
   localparam logic [3:0]  WaitInit = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   dmem_state_e r_state, w_state_d;
   logic [3:0]  r_cnt, w_cnt_d;

   // Captured request
   logic [DEPTH_LOG2-1:0] r_idx;
   logic [63:0]           r_wdata;
   logic [7:0]            r_wmask;
   logic                  r_re;
   logic                  r_we;
   logic                  r_fault;

   logic                  w_req;
   logic                  w_multi;
   logic                  w_misalign;
   logic                  w_range;
   logic                  w_fault_live;
   logic [DEPTH_LOG2-1:0] w_live_idx;
   logic                  w_enter_resp;
   logic                  w_in_idle;
   logic [DEPTH_LOG2-1:0] w_cur_idx;
   logic [63:0]           w_cur_wdata;
   logic [7:0]            w_cur_wmask;
   logic                  w_cur_re;
   logic                  w_cur_we;
   logic                  w_cur_fault;
   logic                  w_sram_we;
   logic                  w_sram_re;
   logic [63:0]           w_rdata;

   // ---------------------------------------------------------------------
   // Fault checks on the live request
   // ---------------------------------------------------------------------
   assign w_req   = re | we | fencei;
   assign w_multi = (re & we) | (re & fencei) | (we & fencei);
   assign w_range = (data_pc < BASE_ADDR) || (data_pc >= EndAddr);

   always_comb begin
      w_misalign = 1'b0;
      case (data_size)
         SizeB:   w_misalign = 1'b0;
         SizeH:   w_misalign = data_pc[0];
         SizeW:   w_misalign = |data_pc[1:0];
         SizeD:   w_misalign = |data_pc[2:0];
         default: w_misalign = 1'b0;
      endcase
   end

   // fence.i carries no address, so only the multi-strobe check applies to it.
   assign w_fault_live = w_multi | ((re | we) & (w_range | w_misalign));
   assign w_live_idx   = data_pc[DEPTH_LOG2+2:3] - BASE_ADDR[DEPTH_LOG2+2:3];

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
      end
   end

   always_comb begin
      w_state_d    = r_state;
      w_cnt_d      = r_cnt;
      w_enter_resp = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_req) begin
               w_cnt_d = WaitInit;
               if (LATENCY > 1) begin
                  w_state_d = StWait;
               end else begin
                  w_state_d    = StResp;
                  w_enter_resp = 1'b1;
               end
            end
         end
         StWait: begin
            if (r_cnt == 4'd0) begin
               w_state_d    = StResp;
               w_enter_resp = 1'b1;
            end else begin
               w_cnt_d = r_cnt - 4'd1;
            end
         end
         StResp: begin
            if (core_ready) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------
   // Request capture
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx   <= '0;
         r_wdata <= Zero64;
         r_wmask <= 8'd0;
         r_re    <= 1'b0;
         r_we    <= 1'b0;
         r_fault <= 1'b0;
      end else if (r_state == StIdle && w_req) begin
         r_idx   <= w_live_idx;
         r_wdata <= data_o;
         r_wmask <= wlen;
         r_re    <= re;
         r_we    <= we;
         r_fault <= w_fault_live;
      end
   end

   // ---------------------------------------------------------------------
   // SRAM commit. With LATENCY==1 the commit edge is the sample edge, so the
   // live request is used directly; otherwise the captured copy is used.
   // ---------------------------------------------------------------------
   assign w_in_idle   = (r_state == StIdle);
   assign w_cur_idx   = w_in_idle ? w_live_idx   : r_idx;
   assign w_cur_wdata = w_in_idle ? data_o       : r_wdata;
   assign w_cur_wmask = w_in_idle ? wlen         : r_wmask;
   assign w_cur_re    = w_in_idle ? re           : r_re;
   assign w_cur_we    = w_in_idle ? we           : r_we;
   assign w_cur_fault = w_in_idle ? w_fault_live : r_fault;

   // Reset on the commit edge drops the access.
   assign w_sram_we = w_enter_resp & ~rst & w_cur_we & ~w_cur_fault;
   assign w_sram_re = w_enter_resp & ~rst & w_cur_re & ~w_cur_fault;

   ysyx_22051013_dsram #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_dsram (
      .clk     (clk),
      .i_addr  (w_cur_idx),
      .i_we    (w_sram_we),
      .i_wmask (w_cur_wmask),
      .i_wdata (w_cur_wdata),
      .i_re    (w_sram_re),
      .o_rdata (w_rdata)
   );

   // ---------------------------------------------------------------------
   // Outputs, derived from registered state only
   // ---------------------------------------------------------------------
   always_comb begin
      data_valid = 1'b1;
      data_temp  = Zero64;
      resp_err   = 1'b0;
      if (r_state == StResp) begin
         data_valid = 1'b0;
         resp_err   = r_fault;
         if (r_re && !r_fault) begin
            data_temp = w_rdata;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22051013_dmem_responder.sv
module tb_ysyx_22051013_dmem_responder;

   localparam logic [63:0] Base    = 64'h0000_0000_8000_0000;
   localparam int unsigned DLog2   = 12;
   localparam int unsigned Lat     = 2;
   localparam logic [63:0] EndA    = Base + (64'd8 << DLog2);
   localparam int          NumTbl  = 14;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        re = 1'b0, we = 1'b0, fencei = 1'b0, core_ready = 1'b0;
   logic [63:0] data_pc = '0, data_o = '0;
   logic [7:0]  wlen = '0;
   logic [2:0]  data_size = '0;
   logic [63:0] data_temp;
   logic        data_valid;
   logic        resp_err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ysyx_22051013_dmem_responder #(
      .BASE_ADDR  (Base),
      .DEPTH_LOG2 (DLog2),
      .LATENCY    (Lat)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .re         (re),
      .we         (we),
      .fencei     (fencei),
      .core_ready (core_ready),
      .data_pc    (data_pc),
      .data_o     (data_o),
      .wlen       (wlen),
      .data_size  (data_size),
      .data_temp  (data_temp),
      .data_valid (data_valid),
      .resp_err   (resp_err)
   );

   typedef struct {
      string       name;
      bit          re, we, fi;
      logic [63:0] pc, wd;
      logic [7:0]  wl;
      logic [2:0]  sz;
      int          rdelay;
      bit          noise;
      logic [63:0] exp_d;
      logic        exp_e;
   } vec_t;

   vec_t tbl [NumTbl];

   // Byte-addressed reference memory
   logic [7:0] mbytes [longint unsigned];

   function automatic vec_t mk(string n, bit r, bit w, bit f, logic [63:0] pc, logic [63:0] wd,
                               logic [7:0] wl, logic [2:0] sz, int rd, bit noise,
                               logic [63:0] ed, logic ee);
      vec_t v;
      v.name = n; v.re = r; v.we = w; v.fi = f; v.pc = pc; v.wd = wd; v.wl = wl; v.sz = sz;
      v.rdelay = rd; v.noise = noise; v.exp_d = ed; v.exp_e = ee;
      return v;
   endfunction

   function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endfunction

   // Reference model: decides fault / response from the access rules and
   // updates the byte memory for successful stores.
   function automatic void model(inout vec_t v);
      int  nreq;
      bit  oor, mis, flt;
      longint unsigned wa;
      nreq = int'(v.re) + int'(v.we) + int'(v.fi);
      oor  = (v.pc < Base) || (v.pc >= EndA);
      mis  = (v.sz == 3'd1 && v.pc % 2 != 0) || (v.sz == 3'd2 && v.pc % 4 != 0) ||
             (v.sz == 3'd3 && v.pc % 8 != 0);
      flt  = (nreq > 1) || ((v.re || v.we) && (oor || mis));
      wa   = longint'(v.pc) / 8 * 8;
      v.exp_e = flt;
      v.exp_d = 64'd0;
      if (!flt && v.re) begin
         for (int i = 0; i < 8; i++)
            v.exp_d[i*8 +: 8] = mbytes.exists(wa + i) ? mbytes[wa + i] : 8'h00;
      end else if (!flt && v.we) begin
         for (int i = 0; i < 8; i++)
            if (v.wl[i]) mbytes[wa + i] = v.wd[i*8 +: 8];
      end
   endfunction

   task automatic clear_inputs();
      re = 0; we = 0; fencei = 0; data_pc = '0; data_o = '0; wlen = '0; data_size = '0;
   endtask

   // Called at a negedge with the DUT idle.
   task automatic apply(input vec_t v);
      int lat;
      re = v.re; we = v.we; fencei = v.fi; data_pc = v.pc; data_o = v.wd;
      wlen = v.wl; data_size = v.sz; core_ready = 0;
      @(posedge clk);
      @(negedge clk);
      lat = 1;
      if (v.noise) begin
         // Requests outside IDLE must be ignored.
         re = 0; fencei = 0; we = 1; data_pc = Base + 64'h10; data_o = '1; wlen = 8'hFF;
         data_size = 3'd3;
      end else begin
         clear_inputs();
      end
      while (data_valid !== 1'b0 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({v.name, ".latency"}, 64'(lat), 64'(Lat));
      if (data_valid !== 1'b0) begin
         clear_inputs();
         return;
      end
      chk({v.name, ".data"}, data_temp, v.exp_d);
      chk({v.name, ".err"}, 64'(resp_err), 64'(v.exp_e));
      core_ready = (v.rdelay == 0);
      for (int i = 1; i <= v.rdelay; i++) begin
         @(negedge clk);
         chk({v.name, ".hold_valid"}, 64'(data_valid), 64'd0);
         chk({v.name, ".hold_data"}, data_temp, v.exp_d);
         core_ready = (i == v.rdelay);
      end
      @(negedge clk);
      clear_inputs();
      core_ready = 0;
      chk({v.name, ".release"}, 64'(data_valid), 64'd1);
   endtask

   initial begin
      vec_t v;
      logic [63:0] old_word;

      tbl[0]  = mk("sd",       1'b0, 1'b1, 1'b0, Base + 64'h10, 64'h1122334455667788, 8'hFF, 3'd3,
                   0, 1'b0, 64'h0, 1'b0);
      tbl[1]  = mk("ld",       1'b1, 1'b0, 1'b0, Base + 64'h10, 64'h0, 8'h00, 3'd3,
                   0, 1'b0, 64'h1122334455667788, 1'b0);
      tbl[2]  = mk("sb",       1'b0, 1'b1, 1'b0, Base + 64'h12, 64'h0000000000AB0000, 8'h04, 3'd0,
                   0, 1'b0, 64'h0, 1'b0);
      tbl[3]  = mk("ld_sb",    1'b1, 1'b0, 1'b0, Base + 64'h10, 64'h0, 8'h00, 3'd3,
                   0, 1'b0, 64'h1122334455AB7788, 1'b0);
      tbl[4]  = mk("ld_bp",    1'b1, 1'b0, 1'b0, Base + 64'h10, 64'h0, 8'h00, 3'd3,
                   3, 1'b1, 64'h1122334455AB7788, 1'b0);
      tbl[5]  = mk("ld_low",   1'b1, 1'b0, 1'b0, 64'h7FFFFFF8, 64'h0, 8'h00, 3'd3,
                   0, 1'b0, 64'h0, 1'b1);
      tbl[6]  = mk("sw_mis",   1'b0, 1'b1, 1'b0, Base + 64'h12, 64'hFFFFFFFF_FFFFFFFF, 8'hF0, 3'd2,
                   0, 1'b0, 64'h0, 1'b1);
      tbl[7]  = mk("ld_nochg", 1'b1, 1'b0, 1'b0, Base + 64'h10, 64'h0, 8'h00, 3'd3,
                   1, 1'b0, 64'h1122334455AB7788, 1'b0);
      tbl[8]  = mk("re_we",    1'b1, 1'b1, 1'b0, Base + 64'h10, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 3'd3,
                   0, 1'b0, 64'h0, 1'b1);
      tbl[9]  = mk("ld_multi", 1'b1, 1'b0, 1'b0, Base + 64'h10, 64'h0, 8'h00, 3'd3,
                   0, 1'b0, 64'h1122334455AB7788, 1'b0);
      tbl[10] = mk("fencei",   1'b0, 1'b0, 1'b1, Base + 64'h10, 64'h0, 8'h00, 3'd0,
                   0, 1'b0, 64'h0, 1'b0);
      tbl[11] = mk("sd_last",  1'b0, 1'b1, 1'b0, EndA - 64'd8, 64'hA5A5_0F0F_3C3C_9696, 8'hFF, 3'd3,
                   0, 1'b0, 64'h0, 1'b0);
      tbl[12] = mk("ld_last",  1'b1, 1'b0, 1'b0, EndA - 64'd8, 64'h0, 8'h00, 3'd3,
                   0, 1'b0, 64'hA5A5_0F0F_3C3C_9696, 1'b0);
      tbl[13] = mk("ld_end",   1'b1, 1'b0, 1'b0, EndA, 64'h0, 8'h00, 3'd3,
                   0, 1'b0, 64'h0, 1'b1);

      // Reset held for three cycles, then one cycle after release.
      rst = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst.valid", 64'(data_valid), 64'd1);
         chk("rst.data", data_temp, 64'd0);
         chk("rst.err", 64'(resp_err), 64'd0);
      end
      rst = 0;
      @(negedge clk);
      chk("rst_rel.valid", 64'(data_valid), 64'd1);
      chk("rst_rel.data", data_temp, 64'd0);

      // Directed table; the model tracks memory so random traffic stays consistent.
      for (int i = 0; i < NumTbl; i++) begin
         apply(tbl[i]);
         v = tbl[i];
         model(v);
      end

      // Reset during WAIT drops the uncommitted store.
      old_word = 64'h1122334455AB7788;
      we = 1; data_pc = Base + 64'h10; data_o = 64'hDEADBEEF_CAFEF00D; wlen = 8'hFF;
      data_size = 3'd3;
      @(posedge clk);
      @(negedge clk);
      clear_inputs();
      rst = 1;
      @(negedge clk);
      chk("rst_wait.valid", 64'(data_valid), 64'd1);
      chk("rst_wait.data", data_temp, 64'd0);
      rst = 0;
      @(negedge clk);
      chk("rst_wait.idle", 64'(data_valid), 64'd1);
      apply(mk("ld_after_rst", 1'b1, 1'b0, 1'b0, Base + 64'h10, 64'h0, 8'h00, 3'd3, 0, 1'b0,
               old_word, 1'b0));

      // Randomized traffic against the reference model.
      for (int w = 0; w < 8; w++) begin
         v = mk("rnd_init", 1'b0, 1'b1, 1'b0, Base + 64'h100 + 64'(w * 8), {$urandom, $urandom},
                8'hFF, 3'd3, 0, 1'b0, 64'h0, 1'b0);
         model(v);
         apply(v);
      end
      for (int n = 0; n < 60; n++) begin
         int kind;
         logic [63:0] pc;
         logic [2:0]  bits;
         kind = $urandom_range(0, 9);
         pc   = Base + 64'h100 + 64'($urandom_range(0, 7) * 8) + 64'($urandom_range(0, 7));
         v = mk("rnd", 1'b0, 1'b0, 1'b0, pc, {$urandom, $urandom}, 8'($urandom),
                3'($urandom_range(0, 3)), $urandom_range(0, 2), 1'b0, 64'h0, 1'b0);
         if (kind <= 3) v.re = 1;
         else if (kind <= 6) v.we = 1;
         else if (kind == 7) v.fi = 1;
         else if (kind == 8) begin
            bits = 3'($urandom_range(3, 7));
            if (bits == 3'd4) bits = 3'd5;
            {v.re, v.we, v.fi} = bits;
         end else begin
            v.re = 1;
            v.pc = ($urandom_range(0, 1) == 0) ? 64'h7FFF_FF00 + 64'($urandom_range(0, 255))
                                              : EndA + 64'($urandom_range(0, 255));
         end
         model(v);
         apply(v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
